pps_capture: RTL and testbench

Receive side of the seconds-timer path. Synchronises an external 1 Hz reference pulse (`pps_in`) into the `clk` domain, timestamps each rising edge with the current `timer` seconds count, and measures the clock-cycle period between edges. It runs a lost/acquire/locked monitor against the nominal period and hands each capture to the line-scanner control logic over a valid/ack handshake.

---
 rtl/timer_pkg.sv | 13 +
 rtl/pps_capture_if.sv | 12 +
 rtl/pulse_sync.sv | 28 ++
 rtl/pps_capture.sv | 125 ++++++++++++
 tb/tb_pps_capture.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared seconds-timer definitions: pulse-monitor state encoding and nominal period defaults.
package timer_pkg;

  typedef enum logic [1:0] {
    LOST   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } pps_state_t;

  localparam logic [31:0] DEF_CLK_CNT = 32'd25000000;
  localparam logic [31:0] DEF_TOL     = 32'd1000;

endpackage

// File: rtl/pps_capture_if.sv
// Capture hand-off bundle: timestamp and period, qualified by cap_valid, accepted by cap_ack.
interface pps_capture_if;

  logic [31:0] cap_sec;
  logic [31:0] period;
  logic        cap_valid;
  logic        cap_ack;

  modport master (output cap_sec, output period, output cap_valid, input cap_ack);
  modport slave  (input cap_sec, input period, input cap_valid, output cap_ack);

endinterface

// File: rtl/pulse_sync.sv
// Two-flop synchroniser for the reference pulse plus edge detect; rise is 1 cycle wide.
// Rise asserts in the second cycle after pps_in is first sampled high; no backpressure.
module pulse_sync (
  input  logic clk,
  input  logic reset,
  input  logic pps_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= pps_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/pps_capture.sv
// Timestamps reference-pulse edges, measures their period and tracks lock; capture regs load 2 edges after pps_in.
// A single capture register: a new capture overwrites unacknowledged data and sets sticky overrun.
module pps_capture import timer_pkg::*; #(
  parameter logic [31:0] CLK_CNT = DEF_CLK_CNT,
  parameter logic [31:0] TOL     = DEF_TOL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pps_in,
  input  logic [31:0]          tim,
  pps_capture_if.master        cap,
  output logic                 overrun,
  output logic                 locked,
  output logic                 lost
);

  localparam logic [32:0] LO_BOUND = {1'b0, CLK_CNT} - {1'b0, TOL};
  localparam logic [32:0] HI_BOUND = {1'b0, CLK_CNT} + {1'b0, TOL};
  localparam logic [31:0] TIMEOUT  = HI_BOUND[31:0];

  logic        rise;
  logic [31:0] sub_cnt;
  logic [31:0] meas;
  logic        in_range;
  pps_state_t  state;
  pps_state_t  state_nxt;
  logic [1:0]  good_cnt;
  logic [1:0]  good_nxt;
  logic        issue;
  logic [31:0] cap_sec_q;
  logic [31:0] period_q;
  logic        cap_valid_q;

  pulse_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pps_in (pps_in),
    .rise   (rise)
  );

  assign meas     = sub_cnt + 32'd1;
  assign in_range = ({1'b0, meas} >= LO_BOUND) && ({1'b0, meas} <= HI_BOUND);

  // Saturating so a long-dead reference cannot wrap back into range.
  always_ff @(posedge clk) begin
    if (reset || rise) begin
      sub_cnt <= 32'd0;
    end else if (sub_cnt != 32'hFFFF_FFFF) begin
      sub_cnt <= sub_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOST;
      good_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    issue     = 1'b0;
    unique case (state)
      LOST: begin
        if (rise) begin
          state_nxt = ACQ;
          good_nxt  = 2'd0;
        end
      end
      ACQ: begin
        if (rise) begin
          issue = 1'b1;
          if (in_range) begin
            good_nxt = good_cnt + 2'd1;
            if (good_cnt == 2'd1) state_nxt = LOCKED;
          end else begin
            good_nxt = 2'd0;
          end
        end else if (sub_cnt == TIMEOUT) begin
          state_nxt = LOST;
        end
      end
      LOCKED: begin
        if (rise) begin
          issue = 1'b1;
          if (!in_range) begin
            state_nxt = ACQ;
            good_nxt  = 2'd0;
          end
        end else if (sub_cnt == TIMEOUT) begin
          state_nxt = LOST;
        end
      end
      default: state_nxt = LOST;
    endcase
  end

  // An ack coinciding with a new capture retires the old data, so no overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_sec_q   <= 32'd0;
      period_q    <= 32'd0;
      cap_valid_q <= 1'b0;
      overrun     <= 1'b0;
    end else if (issue) begin
      cap_sec_q   <= tim;
      period_q    <= meas;
      cap_valid_q <= 1'b1;
      if (cap_valid_q && !cap.cap_ack) overrun <= 1'b1;
    end else if (cap_valid_q && cap.cap_ack) begin
      cap_valid_q <= 1'b0;
    end
  end

  assign cap.cap_sec   = cap_sec_q;
  assign cap.period    = period_q;
  assign cap.cap_valid = cap_valid_q;
  assign locked        = (state == LOCKED);
  assign lost          = (state == LOST);

endmodule

// File: tb/tb_pps_capture.sv
// Directed bench for pps_capture with CLK_CNT=100, TOL=2; inputs driven and outputs sampled on negedge.
module tb_pps_capture;

  logic        clk;
  logic        reset;
  logic        pps_in;
  logic [31:0] tim;
  logic        overrun;
  logic        locked;
  logic        lost;

  int vec_cnt    = 0;
  int err_cnt    = 0;
  int cyc        = 0;
  int last_raise = 0;
  int hi_left    = 0;

  pps_capture_if cap_if ();

  pps_capture #(
    .CLK_CNT (32'd100),
    .TOL     (32'd2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pps_in  (pps_in),
    .tim     (tim),
    .cap     (cap_if),
    .overrun (overrun),
    .locked  (locked),
    .lost    (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle; pps_in drops after being sampled high on 3 edges.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (hi_left > 0) begin
      hi_left--;
      if (hi_left == 0) pps_in = 1'b0;
    end
  endtask

  task automatic raise(input logic [31:0] t);
    tim        = t;
    pps_in     = 1'b1;
    hi_left    = 3;
    last_raise = cyc;
  endtask

  task automatic wait_until(input int gap);
    while (cyc - last_raise < gap) step();
  endtask

  task automatic accept();
    cap_if.cap_ack = 1'b1;
    step();
    cap_if.cap_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    vec_cnt++; if (cap_if.cap_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %0b want 0", cap_if.cap_valid); end
    vec_cnt++; if (cap_if.cap_sec !== 32'd0) begin err_cnt++; $display("FAIL rst_sec: got %0d want 0", cap_if.cap_sec); end
    vec_cnt++; if (cap_if.period !== 32'd0) begin err_cnt++; $display("FAIL rst_period: got %0d want 0", cap_if.period); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
    vec_cnt++; if (locked !== 1'b0) begin err_cnt++; $display("FAIL rst_locked: got %0b want 0", locked); end
    vec_cnt++; if (lost !== 1'b1) begin err_cnt++; $display("FAIL rst_lost: got %0b want 1", lost); end
  endtask

  task automatic test_acquire();
    raise(32'd5);
    step(); step(); step();
    vec_cnt++; if (cap_if.cap_valid !== 1'b0) begin err_cnt++; $display("FAIL arm_no_cap: got %0b want 0", cap_if.cap_valid); end
    vec_cnt++; if (lost !== 1'b0 || locked !== 1'b0) begin err_cnt++; $display("FAIL arm_state: lost=%0b locked=%0b want 0 0", lost, locked); end

    wait_until(100);
    raise(32'd6);
    step(); step();
    vec_cnt++; if (cap_if.cap_valid !== 1'b0) begin err_cnt++; $display("FAIL cap6_early: got %0b want 0", cap_if.cap_valid); end
    step();
    vec_cnt++; if (cap_if.cap_valid !== 1'b1) begin err_cnt++; $display("FAIL cap6_valid: got %0b want 1", cap_if.cap_valid); end
    vec_cnt++; if (cap_if.cap_sec !== 32'd6) begin err_cnt++; $display("FAIL cap6_sec: got %0d want 6", cap_if.cap_sec); end
    vec_cnt++; if (cap_if.period !== 32'd100) begin err_cnt++; $display("FAIL cap6_period: got %0d want 100", cap_if.period); end
    vec_cnt++; if (locked !== 1'b0) begin err_cnt++; $display("FAIL cap6_locked: got %0b want 0", locked); end
    accept();
    vec_cnt++; if (cap_if.cap_valid !== 1'b0) begin err_cnt++; $display("FAIL cap6_ack: got %0b want 0", cap_if.cap_valid); end

    wait_until(100);
    raise(32'd7);
    step(); step(); step();
    vec_cnt++; if (cap_if.cap_sec !== 32'd7 || cap_if.period !== 32'd100) begin err_cnt++; $display("FAIL cap7_data: got %0d/%0d want 7/100", cap_if.cap_sec, cap_if.period); end
    vec_cnt++; if (locked !== 1'b1) begin err_cnt++; $display("FAIL cap7_locked: got %0b want 1", locked); end

    // Capture 7 left pending; capture 8 arrives with an ack in the same cycle.
    wait_until(100);
    raise(32'd8);
    step(); step();
    cap_if.cap_ack = 1'b1;
    step();
    cap_if.cap_ack = 1'b0;
    vec_cnt++; if (cap_if.cap_valid !== 1'b1) begin err_cnt++; $display("FAIL cap8_valid: got %0b want 1", cap_if.cap_valid); end
    vec_cnt++; if (cap_if.cap_sec !== 32'd8 || cap_if.period !== 32'd100) begin err_cnt++; $display("FAIL cap8_data: got %0d/%0d want 8/100", cap_if.cap_sec, cap_if.period); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL cap8_overrun: got %0b want 0", overrun); end
    accept();
  endtask

  task automatic test_short_period();
    wait_until(97);
    raise(32'd9);
    step(); step(); step();
    vec_cnt++; if (cap_if.period !== 32'd97 || cap_if.cap_sec !== 32'd9) begin err_cnt++; $display("FAIL short_data: got %0d/%0d want 9/97", cap_if.cap_sec, cap_if.period); end
    vec_cnt++; if (locked !== 1'b0 || lost !== 1'b0) begin err_cnt++; $display("FAIL short_state: locked=%0b lost=%0b want 0 0", locked, lost); end
    accept();
    wait_until(100);
    raise(32'd10);
    step(); step(); step();
    vec_cnt++; if (locked !== 1'b0) begin err_cnt++; $display("FAIL relock1: got %0b want 0", locked); end
    accept();
    wait_until(100);
    raise(32'd11);
    step(); step(); step();
    vec_cnt++; if (locked !== 1'b1) begin err_cnt++; $display("FAIL relock2: got %0b want 1", locked); end
    accept();
  endtask

  task automatic test_loss();
    wait_until(105);
    vec_cnt++; if (lost !== 1'b0 || locked !== 1'b1) begin err_cnt++; $display("FAIL pre_timeout: lost=%0b locked=%0b want 0 1", lost, locked); end
    step();
    vec_cnt++; if (lost !== 1'b1 || locked !== 1'b0) begin err_cnt++; $display("FAIL timeout: lost=%0b locked=%0b want 1 0", lost, locked); end
    raise(32'd20);
    step(); step(); step();
    vec_cnt++; if (cap_if.cap_valid !== 1'b0) begin err_cnt++; $display("FAIL rearm_no_cap: got %0b want 0", cap_if.cap_valid); end
    vec_cnt++; if (lost !== 1'b0) begin err_cnt++; $display("FAIL rearm_state: lost=%0b want 0", lost); end
  endtask

  task automatic test_timeout_edge();
    wait_until(103);
    raise(32'd21);
    step(); step(); step();
    vec_cnt++; if (cap_if.cap_valid !== 1'b1) begin err_cnt++; $display("FAIL edge_valid: got %0b want 1", cap_if.cap_valid); end
    vec_cnt++; if (cap_if.period !== 32'd103 || cap_if.cap_sec !== 32'd21) begin err_cnt++; $display("FAIL edge_data: got %0d/%0d want 21/103", cap_if.cap_sec, cap_if.period); end
    vec_cnt++; if (lost !== 1'b0 || locked !== 1'b0) begin err_cnt++; $display("FAIL edge_state: lost=%0b locked=%0b want 0 0", lost, locked); end
    accept();
  endtask

  task automatic test_overrun();
    wait_until(100);
    raise(32'd30);
    step(); step(); step();
    vec_cnt++; if (overrun !== 1'b0 || cap_if.cap_valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_first: overrun=%0b valid=%0b want 0 1", overrun, cap_if.cap_valid); end
    wait_until(100);
    raise(32'd31);
    step(); step(); step();
    vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_set: got %0b want 1", overrun); end
    vec_cnt++; if (cap_if.cap_sec !== 32'd31 || cap_if.period !== 32'd100) begin err_cnt++; $display("FAIL ovr_data: got %0d/%0d want 31/100", cap_if.cap_sec, cap_if.period); end
    wait_until(100);
    raise(32'd32);
    step(); step();
    cap_if.cap_ack = 1'b1;
    step();
    cap_if.cap_ack = 1'b0;
    vec_cnt++; if (cap_if.cap_valid !== 1'b1 || cap_if.cap_sec !== 32'd32) begin err_cnt++; $display("FAIL ovr_ack_same: valid=%0b sec=%0d want 1 32", cap_if.cap_valid, cap_if.cap_sec); end
    vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    wait_until(50);
    pps_in  = 1'b1;
    hi_left = 0;
    reset   = 1'b1;
    step();
    vec_cnt++; if (cap_if.cap_valid !== 1'b0 || cap_if.cap_sec !== 32'd0 || cap_if.period !== 32'd0) begin err_cnt++; $display("FAIL mid_rst_cap: valid=%0b sec=%0d period=%0d want 0 0 0", cap_if.cap_valid, cap_if.cap_sec, cap_if.period); end
    vec_cnt++; if (overrun !== 1'b0 || locked !== 1'b0 || lost !== 1'b1) begin err_cnt++; $display("FAIL mid_rst_status: overrun=%0b locked=%0b lost=%0b want 0 0 1", overrun, locked, lost); end
    step();
    reset = 1'b0;
    step(); step();
    vec_cnt++; if (lost !== 1'b1) begin err_cnt++; $display("FAIL rel_before_rise: lost=%0b want 1", lost); end
    step();
    vec_cnt++; if (lost !== 1'b0 || cap_if.cap_valid !== 1'b0) begin err_cnt++; $display("FAIL rel_arm: lost=%0b valid=%0b want 0 0", lost, cap_if.cap_valid); end
    step(); step();
    vec_cnt++; if (cap_if.cap_valid !== 1'b0 || lost !== 1'b0) begin err_cnt++; $display("FAIL rel_single_rise: valid=%0b lost=%0b want 0 0", cap_if.cap_valid, lost); end
    pps_in = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    pps_in         = 1'b0;
    tim            = 32'd0;
    cap_if.cap_ack = 1'b0;
    test_reset();
    test_acquire();
    test_short_period();
    test_loss();
    test_timeout_edge();
    test_overrun();
    test_reset_mid();
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
